// File: rtl/pattern_match_ctrl.sv
// Sequencing controller for the 256-bit serial pattern decoder: loads a byte-streamed pattern
// MSB-first, then arms rising-edge match detection. Optional macro: PATTERN_MATCH_CTRL_LOAD_TIMEOUT_EN.
module pattern_match_ctrl #(
   parameter int WIDTH  = 256,
   parameter int BYTE_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic              disarm,
   input  logic [BYTE_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              prgm_bit,
   output logic              prgm_en,
   input  logic              match_in,
   output logic              busy,
   output logic              armed,
   output logic              hit,
   output logic [CNT_W-1:0]  hit_count,
   output logic              load_err
);

   localparam int BITS_W = $clog2(WIDTH + 1);
   localparam int POS_W  = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      SHIFT     = 2'd2,
      ARMED     = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [BYTE_W-1:0]   shift_q, shift_d;
   logic [BITS_W-1:0]   bitCnt_q, bitCnt_d;
   logic [POS_W-1:0]    bitPos_q, bitPos_d;
   logic [CNT_W-1:0]    hitCnt_q, hitCnt_d;
   logic                match_q, match_d;
   logic                hit_q, hit_d;
   logic                cfgReady_q, cfgReady_d;
   logic                prgmBit_q, prgmBit_d;
   logic                prgmEn_q, prgmEn_d;
   logic                busy_q, busy_d;
   logic                armed_q, armed_d;
   logic                accept;
   logic                timeout;

   assign accept = (state_q == LOAD_WAIT) && cfgReady_q && cfg_valid;

`ifdef PATTERN_MATCH_CTRL_LOAD_TIMEOUT_EN
   logic [9:0] idleCnt_q;
   logic       loadErr_q;

   assign timeout = (state_q == LOAD_WAIT) && !accept && (idleCnt_q == 10'h3FF);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         idleCnt_q <= '0;
         loadErr_q <= 1'b0;
      end else begin
         if (state_q != LOAD_WAIT || accept) begin
            idleCnt_q <= '0;
         end else begin
            idleCnt_q <= idleCnt_q + 10'd1;
         end
         if (state_q == IDLE && start) begin
            loadErr_q <= 1'b0;
         end else if (timeout) begin
            loadErr_q <= 1'b1;
         end
      end
   end

   assign load_err = loadErr_q;
`else
   assign timeout  = 1'b0;
   assign load_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bitCnt_q   <= '0;
         bitPos_q   <= '0;
         hitCnt_q   <= '0;
         match_q    <= 1'b0;
         hit_q      <= 1'b0;
         cfgReady_q <= 1'b0;
         prgmBit_q  <= 1'b0;
         prgmEn_q   <= 1'b0;
         busy_q     <= 1'b0;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bitCnt_q   <= bitCnt_d;
         bitPos_q   <= bitPos_d;
         hitCnt_q   <= hitCnt_d;
         match_q    <= match_d;
         hit_q      <= hit_d;
         cfgReady_q <= cfgReady_d;
         prgmBit_q  <= prgmBit_d;
         prgmEn_q   <= prgmEn_d;
         busy_q     <= busy_d;
         armed_q    <= armed_d;
      end
   end

   // Outputs are registered copies of the next-state decode, so they line up with state_q.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bitCnt_d = bitCnt_q;
      bitPos_d = bitPos_q;
      hitCnt_d = hitCnt_q;
      match_d  = 1'b0;
      hit_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = LOAD_WAIT;
               hitCnt_d = '0;
               bitCnt_d = '0;
               bitPos_d = '0;
            end
         end
         LOAD_WAIT: begin
            if (accept) begin
               shift_d  = cfg_data;
               bitPos_d = '0;
               state_d  = SHIFT;
            end else if (timeout) begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            shift_d  = shift_q << 1;
            bitCnt_d = bitCnt_q + 1'b1;
            bitPos_d = bitPos_q + 1'b1;
            if (bitPos_q == POS_W'(BYTE_W - 1)) begin
               bitPos_d = '0;
               state_d  = (bitCnt_q == BITS_W'(WIDTH - 1)) ? ARMED : LOAD_WAIT;
            end
         end
         ARMED: begin
            if (disarm) begin
               state_d = IDLE;
            end else if (start) begin
               state_d  = LOAD_WAIT;
               hitCnt_d = '0;
               bitCnt_d = '0;
               bitPos_d = '0;
            end else begin
               match_d = match_in;
               if (match_in && !match_q) begin
                  hit_d = 1'b1;
                  if (hitCnt_q != {CNT_W{1'b1}}) begin
                     hitCnt_d = hitCnt_q + 1'b1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      cfgReady_d = (state_d == LOAD_WAIT);
      prgmEn_d   = (state_d == SHIFT);
      prgmBit_d  = (state_d == SHIFT) ? shift_d[BYTE_W-1] : 1'b0;
      busy_d     = (state_d == LOAD_WAIT) || (state_d == SHIFT);
      armed_d    = (state_d == ARMED);
   end

   assign cfg_ready = cfgReady_q;
   assign prgm_bit  = prgmBit_q;
   assign prgm_en   = prgmEn_q;
   assign busy      = busy_q;
   assign armed     = armed_q;
   assign hit       = hit_q;
   assign hit_count = hitCnt_q;

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Randomized bench for pattern_match_ctrl: checks the serialized bit stream against the bytes sent
// and hit pulses/count against a rising-edge counting model. Honours PATTERN_MATCH_CTRL_LOAD_TIMEOUT_EN.
module tb_pattern_match_ctrl;

   localparam int WIDTH   = 256;
   localparam int BYTE_W  = 8;
   localparam int CNT_W   = 8;
   localparam int NBYTES  = WIDTH / BYTE_W;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int LIMIT   = 100;

   logic              clk = 1'b0;
   logic              clr = 1'b0;
   logic              start = 1'b0;
   logic              disarm = 1'b0;
   logic [BYTE_W-1:0] cfg_data = '0;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready;
   logic              prgm_bit;
   logic              prgm_en;
   logic              match_in = 1'b0;
   logic              busy;
   logic              armed;
   logic              hit;
   logic [CNT_W-1:0]  hit_count;
   logic              load_err;

   always #5 clk = ~clk;

   pattern_match_ctrl #(.WIDTH(WIDTH), .BYTE_W(BYTE_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .clr(clr), .start(start), .disarm(disarm),
      .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .prgm_bit(prgm_bit), .prgm_en(prgm_en), .match_in(match_in),
      .busy(busy), .armed(armed), .hit(hit), .hit_count(hit_count), .load_err(load_err)
   );

   int checksTotal = 0;
   int checksPassed = 0;

   bit                rxBits[$];
   int                runLen = 0;
   int                runErrs = 0;
   logic [BYTE_W-1:0] expBytes[$];
   int                expCount = 0;
   bit                modelPrev = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checksTotal++;
      if (actual === expected) checksPassed++;
      else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
   endtask

   // Collects every programmed bit and verifies each enable burst covers whole bytes.
   always @(negedge clk) begin
      if (!clr) begin
         runLen = 0;
      end else if (prgm_en) begin
         rxBits.push_back(prgm_bit);
         runLen++;
      end else if (runLen != 0) begin
         if (runLen % BYTE_W != 0) runErrs++;
         runLen = 0;
      end
   end

   task automatic pulseStart();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic sendByte(input logic [BYTE_W-1:0] b);
      int guard;
      guard = 0;
      cfg_data  = b;
      cfg_valid = 1'b1;
      while (!cfg_ready && guard < LIMIT) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= LIMIT) checkOutput("cfg_ready_wait", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic waitArmed();
      int guard;
      guard = 0;
      while (!armed && guard < LIMIT) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("armed_after_load", armed, 1);
      @(negedge clk);
      modelPrev = 1'b0;
      expCount  = 0;
   endtask

   task automatic applyStimulus(input int maxGap, input bit useA5);
      int errs;
      expBytes.delete();
      rxBits.delete();
      runErrs = 0;
      for (int i = 0; i < NBYTES; i++) begin
         logic [BYTE_W-1:0] b;
         b = useA5 ? BYTE_W'(8'hA5) : BYTE_W'($urandom);
         expBytes.push_back(b);
         sendByte(b);
         if (maxGap > 0) begin
            cfg_valid = 1'b0;
            repeat ($urandom_range(maxGap, 1)) @(negedge clk);
         end
      end
      cfg_valid = 1'b0;
      waitArmed();
      checkOutput("prgm_en_cycles", rxBits.size(), WIDTH);
      errs = 0;
      for (int i = 0; i < rxBits.size() && i < WIDTH; i++) begin
         if (rxBits[i] != expBytes[i / BYTE_W][BYTE_W - 1 - (i % BYTE_W)]) errs++;
      end
      checkOutput("bit_stream_errs", errs, 0);
      checkOutput("byte_run_errs", runErrs, 0);
      checkOutput("busy_when_armed", busy, 0);
      checkOutput("cfg_ready_when_armed", cfg_ready, 0);
      checkOutput("hit_count_after_load", hit_count, 0);
   endtask

   task automatic applyMatch(input bit m);
      bit expHit;
      match_in = m;
      @(negedge clk);
      expHit    = m && !modelPrev;
      modelPrev = m;
      if (expHit && expCount < CNT_MAX) expCount++;
      checkOutput("hit", hit, expHit);
      checkOutput("hit_count", hit_count, expCount);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] firstByte;
      int saved;

      repeat (3) @(negedge clk);
      checkOutput("reset_flags", {cfg_ready, prgm_bit, prgm_en, busy, armed, hit, load_err}, 0);
      checkOutput("reset_hit_count", hit_count, 0);
      clr = 1'b1;
      @(negedge clk);
      checkOutput("idle_flags", {cfg_ready, prgm_en, busy, armed}, 0);

      $display("[TB] back-to-back 0xA5 load");
      pulseStart();
      checkOutput("busy_after_start", busy, 1);
      applyStimulus(0, 1'b1);
      firstByte = '0;
      for (int k = 0; k < 8 && k < rxBits.size(); k++) firstByte[7-k] = rxBits[k];
      checkOutput("first_byte_a5", firstByte, 8'hA5);

      $display("[TB] match 5 high, 3 low, 1 high");
      for (int k = 0; k < 5; k++) applyMatch(1'b1);
      for (int k = 0; k < 3; k++) applyMatch(1'b0);
      applyMatch(1'b1);
      applyMatch(1'b0);
      applyMatch(1'b0);
      checkOutput("hit_count_pattern", hit_count, 2);

      $display("[TB] random match stream");
      for (int k = 0; k < 60; k++) applyMatch(1'($urandom_range(1, 0)));
      match_in = 1'b0;
      @(negedge clk);
      modelPrev = 1'b0;

      $display("[TB] start and disarm together");
      saved  = expCount;
      start  = 1'b1;
      disarm = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      disarm = 1'b0;
      checkOutput("disarm_wins_armed", armed, 0);
      checkOutput("disarm_wins_busy", busy, 0);
      checkOutput("disarm_count_held", hit_count, saved);
      pulseStart();
      checkOutput("restart_busy", busy, 1);
      checkOutput("restart_count_clr", hit_count, 0);

      $display("[TB] load with random gaps");
      applyStimulus(5, 1'b0);

      $display("[TB] counter saturation");
      for (int k = 0; k < CNT_MAX - 1; k++) begin
         applyMatch(1'b1);
         applyMatch(1'b0);
      end
      checkOutput("count_max_minus_1", hit_count, CNT_MAX - 1);
      for (int k = 0; k < 3; k++) begin
         applyMatch(1'b1);
         applyMatch(1'b0);
      end
      checkOutput("count_saturated", hit_count, CNT_MAX);

      $display("[TB] reload from armed, reset during byte 10");
      pulseStart();
      checkOutput("reload_busy", busy, 1);
      checkOutput("reload_count_clr", hit_count, 0);
      for (int i = 0; i < 11; i++) sendByte(BYTE_W'($urandom));
      checkOutput("shifting_byte10", prgm_en, 1);
      #2;
      clr = 1'b0;
      #1;
      checkOutput("async_clear_flags", {cfg_ready, prgm_bit, prgm_en, busy, armed, hit, load_err}, 0);
      checkOutput("async_clear_count", hit_count, 0);
      cfg_valid = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      checkOutput("idle_after_clear", {cfg_ready, busy, armed}, 0);
      pulseStart();
      applyStimulus(2, 1'b0);

      $display("[TB] stalled load");
      disarm = 1'b1;
      @(negedge clk);
      disarm = 1'b0;
      checkOutput("disarm_alone", armed, 0);
      pulseStart();
      repeat (1000) @(negedge clk);
      checkOutput("stall_still_busy", busy, 1);
      checkOutput("stall_no_err_yet", load_err, 0);
      repeat (40) @(negedge clk);
`ifdef PATTERN_MATCH_CTRL_LOAD_TIMEOUT_EN
      checkOutput("timeout_idle", busy, 0);
      checkOutput("timeout_load_err", load_err, 1);
      checkOutput("timeout_no_prgm_en", prgm_en, 0);
      pulseStart();
      checkOutput("load_err_cleared", load_err, 0);
      checkOutput("restart_after_timeout", busy, 1);
`else
      checkOutput("waits_forever_busy", busy, 1);
      checkOutput("load_err_tied", load_err, 0);
`endif

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule

// File: doc/pattern_match_ctrl.md
Name: pattern_match_ctrl

Overview:
- Sequencing controller for the 256-bit serial pattern decoder (program SIPO + signal SIPO + equality comparator).
- Accepts a pattern as a byte stream over a valid/ready handshake and serializes it onto the decoder's program bit/enable inputs.
- Then arms detection, edge-detects the comparator's equality output, and counts and flags hits.
- Sits between the host configuration bus and the decoder instance.

Parameters:
- WIDTH, 256, pattern length in bits; must equal the decoder register width and be a multiple of BYTE_W.
- BYTE_W, 8, width of one configuration beat.
- CNT_W, 16, hit counter width.

Ports:
- clk  input  1  single system clock, rising-edge.
- clr  input  1  reset, asynchronous, active-low; all state is cleared while clr=0.
- start  input  1  level sampled per cycle; 1 requests a (re)load of the pattern.
- disarm  input  1  1 in ARMED returns to IDLE.
- cfg_data  input  BYTE_W  pattern byte.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  controller can accept a byte this cycle.
- prgm_bit  output  1  serial pattern bit to the decoder program input.
- prgm_en  output  1  shift enable to the decoder program register.
- match_in  input  1  decoder equality output.
- busy  output  1  high in LOAD_WAIT or SHIFT.
- armed  output  1  high in ARMED.
- hit  output  1  one-cycle hit pulse.
- hit_count  output  CNT_W  number of hits since the last load.
- load_err  output  1  sticky load-timeout flag (see Optional Feature).

Behaviour:
- Reset values:
  - state=IDLE.
  - cfg_ready, prgm_bit, prgm_en, busy, armed, hit, load_err = 0.
  - hit_count=0; internal bit counter=0; match_q=0.
- States:
  - IDLE, LOAD_WAIT, SHIFT, ARMED. All outputs are registered.
- IDLE:
  - start=1 -> LOAD_WAIT; clear hit_count, bit counter and load_err.
- LOAD_WAIT:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready, capture cfg_data into the shift byte -> SHIFT.
- SHIFT:
  - cfg_ready=0.
  - Each cycle present one bit, MSB first, with prgm_en=1.
  - Exactly BYTE_W cycles per byte. Byte 0 is first on the wire.
  - After the byte's last bit:
    - If the total bit count reaches WIDTH -> ARMED.
    - Otherwise -> LOAD_WAIT.
  - prgm_en is high for exactly WIDTH cycles per load. Cycles need not be contiguous; gaps occur while waiting for bytes.
  - prgm_en=0 in every other state.
- Handshake:
  - cfg_data and cfg_valid may change only after an accept.
  - cfg_valid while cfg_ready=0 is ignored. The byte is not lost; the host holds it.
- ARMED:
  - match_q <= match_in every cycle; match_q is cleared on entry.
  - hit=1 in the cycle after an edge where match_in=1 and match_q=0, i.e. rising-edge detection. A sustained match counts once.
  - hit_count increments with hit and saturates at all-ones.
  - match_in is ignored outside ARMED.
- disarm=1 in ARMED:
  - -> IDLE.
  - hit_count is held and readable.
- start=1 in ARMED (with disarm=0):
  - -> LOAD_WAIT; hit_count is cleared.
- Priority: disarm and start together in ARMED -> disarm wins.
- start in LOAD_WAIT or SHIFT: ignored. A load cannot be restarted except by reset.
- Reset mid-load:
  - Controller returns to IDLE immediately.
  - Decoder program contents are undefined until the next complete load; the decoder's own clear is not driven by this block.
- busy = (LOAD_WAIT or SHIFT). armed = (state==ARMED).

Optional Feature:
- Macro: PATTERN_MATCH_CTRL_LOAD_TIMEOUT_EN.
- Defined:
  - A 10-bit idle counter runs in LOAD_WAIT and resets on every accept.
  - If 1024 consecutive LOAD_WAIT cycles pass without an accept: abort to IDLE, set load_err=1 (sticky until the next start in IDLE or reset), prgm_en stays 0.
- Not defined:
  - No counter logic.
  - load_err is tied 0.
  - LOAD_WAIT waits indefinitely.

Test Plan:
- Reset, then drive 32 bytes 0xA5 back-to-back with cfg_valid=1 -> prgm_en high for exactly 256 cycles; prgm_bit sequence 1,0,1,0,0,1,0,1 repeated; armed=1 after the last bit; busy=0.
- Load with random 1-5 cycle cfg_valid gaps -> prgm_en count is still 256, each byte's bits are contiguous, and no bytes are dropped or duplicated.
- ARMED, match_in high for 5 cycles, low for 3, high for 1 -> exactly 2 hit pulses, each one cycle after the rising edge; hit_count=2.
- ARMED with hit_count=0xFFFE, 3 match rising edges -> hit_count=0xFFFF and stays there.
- ARMED with start=1 and disarm=1 in the same cycle -> IDLE, hit_count unchanged. Next cycle start=1 -> LOAD_WAIT, hit_count=0.
- Pull clr low during byte 10 of SHIFT -> all outputs 0 asynchronously. With PATTERN_MATCH_CTRL_LOAD_TIMEOUT_EN defined, stall 1024 cycles in LOAD_WAIT -> IDLE with load_err=1.
